// File: rtl/elem_sync_fifo.sv
// elem_sync_fifo: single-clock element FIFO, any depth, occupancy flags, flush, optional fall-through
module elem_sync_fifo #(
  parameter int ELEM_WIDTH   = 4,
  parameter int FIFO_SIZE    = 2,
  parameter int AF_THRESH    = FIFO_SIZE - 1,
  parameter int AE_THRESH    = 1,
  parameter int FALL_THROUGH = 0
) (
  input  logic                           clk_i,
  input  logic                           arst_ni,
  input  logic                           flush_i,
  input  logic [ELEM_WIDTH-1:0]          elem_in_i,
  input  logic                           elem_in_valid_i,
  output logic                           elem_in_ready_o,
  output logic [ELEM_WIDTH-1:0]          elem_out_o,
  output logic                           elem_out_valid_o,
  input  logic                           elem_out_ready_i,
  output logic [$clog2(FIFO_SIZE+1)-1:0] count_o,
  output logic                           almost_full_o,
  output logic                           almost_empty_o
);
  localparam int CW = $clog2(FIFO_SIZE + 1);
  localparam int PW = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;
  if (ELEM_WIDTH < 1 || FIFO_SIZE < 2 || AF_THRESH < 1 || AF_THRESH > FIFO_SIZE ||
      AE_THRESH < 0 || AE_THRESH > FIFO_SIZE - 1 || (FALL_THROUGH != 0 && FALL_THROUGH != 1)) begin : g_bad_param
    $fatal(1, "elem_sync_fifo: illegal parameter values");
  end
  logic [ELEM_WIDTH-1:0] mem [FIFO_SIZE];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  empty, full, bypass, push, pop, thru, wr, rd;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_SIZE - 1)) ? '0 : p + PW'(1);
  endfunction
  always_comb begin
    empty            = (count == '0);
    full             = (count == CW'(FIFO_SIZE));
    bypass           = (FALL_THROUGH != 0) && empty;
    elem_in_ready_o  = !full && !flush_i;
    // bypass valid is masked during reset so nothing is presented before release
    elem_out_valid_o = bypass ? (elem_in_valid_i && !flush_i && arst_ni) : (!empty && !flush_i);
    elem_out_o       = bypass ? elem_in_i : mem[rd_ptr];
    push             = elem_in_valid_i && elem_in_ready_o;
    pop              = elem_out_valid_o && elem_out_ready_i;
    thru             = bypass && pop;
    wr               = push && !thru;
    rd               = pop && !thru;
    count_o          = count;
    almost_full_o    = count >= CW'(AF_THRESH);
    almost_empty_o   = count <= CW'(AE_THRESH);
  end
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int i = 0; i < FIFO_SIZE; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) mem[wr_ptr] <= elem_in_i;
      wr_ptr <= wr ? nxt(wr_ptr) : wr_ptr;
      rd_ptr <= rd ? nxt(rd_ptr) : rd_ptr;
      count  <= count + CW'(wr) - CW'(rd);
    end
  end
endmodule

// File: tb/tb_elem_sync_fifo.sv
// tb_elem_sync_fifo: drives one stimulus stream into a stored-only and a fall-through FIFO, scoreboard-checked
module tb_elem_sync_fifo;
  localparam int N = 5;
  logic       clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [3:0] din = 0;
  logic [3:0] out [2];
  logic       in_ready [2], out_valid [2], af [2], ae [2];
  logic [2:0] count [2];
  logic [3:0] q0 [$], q1 [$];
  int         cnt [2];
  int         total = 0, bad = 0;
  always #5 clk = ~clk;
  for (genvar m = 0; m < 2; m++) begin : g_dut
    elem_sync_fifo #(.ELEM_WIDTH(4), .FIFO_SIZE(N), .AF_THRESH(4), .AE_THRESH(1), .FALL_THROUGH(m)) dut (
      .clk_i(clk), .arst_ni(rst_n), .flush_i(flush),
      .elem_in_i(din), .elem_in_valid_i(in_valid), .elem_in_ready_o(in_ready[m]),
      .elem_out_o(out[m]), .elem_out_valid_o(out_valid[m]), .elem_out_ready_i(out_ready),
      .count_o(count[m]), .almost_full_o(af[m]), .almost_empty_o(ae[m]));
  end
  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  // monitor: every output handshake must deliver the oldest outstanding element
  always @(negedge clk) if (rst_n) begin
    if (out_valid[0] && out_ready) begin
      if (q0.size() == 0) chk("m0 unexpected pop", 1, 0);
      else chk("m0 data", out[0], q0.pop_front());
    end
    if (out_valid[1] && out_ready) begin
      if (q1.size() == 0) chk("m1 unexpected pop", 1, 0);
      else chk("m1 data", out[1], q1.pop_front());
    end
  end
  task automatic check_levels();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("m%0d count", m), count[m], cnt[m]);
      chk($sformatf("m%0d af", m), af[m], cnt[m] >= 4);
      chk($sformatf("m%0d ae", m), ae[m], cnt[m] <= 1);
    end
  endtask
  task automatic step(input bit v, input logic [3:0] d, input bit r, input bit f);
    int  ncnt [2];
    bit  er [2], ev [2];
    @(posedge clk); #1;
    in_valid = v; din = d; out_ready = r; flush = f;
    for (int m = 0; m < 2; m++) begin
      bit e, push, pop, thru;
      e     = cnt[m] == 0;
      er[m] = cnt[m] < N && !f;
      ev[m] = (m == 1 && e) ? (v && !f) : (!e && !f);
      push  = v && er[m];
      pop   = ev[m] && r;
      thru  = m == 1 && e && pop;
      if (push) begin
        if (m == 0) q0.push_back(d);
        else q1.push_back(d);
      end
      if (f) begin
        if (m == 0) q0.delete();
        else q1.delete();
      end
      ncnt[m] = f ? 0 : cnt[m] + int'(push && !thru) - int'(pop && !thru);
    end
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("m%0d ready", m), in_ready[m], er[m]);
      chk($sformatf("m%0d valid", m), out_valid[m], ev[m]);
    end
    check_levels();
    cnt = ncnt;
  endtask
  initial begin
    cnt = '{0, 0};
    in_valid = 1; din = 4'h7;
    repeat (10) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("m%0d rst ready", m), in_ready[m], 1);
      chk($sformatf("m%0d rst valid", m), out_valid[m], 0);
    end
    chk("m0 rst out", out[0], 0);
    chk("m1 rst out", out[1], 4'h7);
    check_levels();
    in_valid = 0;
    rst_n = 1;
    // fill past full, then drain
    for (int k = 1; k <= 6; k++) step(1, 4'(k), 0, 0);
    repeat (6) step(0, 0, 1, 0);
    // wrap-around at steady occupancy 3
    for (int k = 0; k < 3; k++) step(1, 4'(k + 8), 0, 0);
    for (int k = 0; k < 20; k++) step(1, 4'(k), 1, 0);
    // flush while a write is offered
    step(1, 4'hA, 0, 1);
    step(0, 0, 0, 0);
    repeat (2) step(0, 0, 1, 0);
    // fall-through: bypass when ready, stored when not
    step(1, 4'hA, 1, 0);
    repeat (2) step(0, 0, 1, 0);
    step(1, 4'hA, 0, 0);
    step(0, 0, 0, 0);
    repeat (2) step(0, 0, 1, 0);
    // asynchronous reset mid-operation
    for (int k = 0; k < 3; k++) step(1, 4'(k + 1), 0, 0);
    @(posedge clk); #3;
    in_valid = 0;
    rst_n = 0;
    #1;
    cnt = '{0, 0};
    q0.delete();
    q1.delete();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("m%0d async count", m), count[m], 0);
      chk($sformatf("m%0d async valid", m), out_valid[m], 0);
    end
    @(negedge clk);
    rst_n = 1;
    step(1, 4'h5, 0, 0);
    repeat (2) step(0, 0, 1, 0);
    // random traffic
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 1), 4'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
    repeat (6) step(0, 0, 1, 0);
    chk("m0 drained", q0.size(), 0);
    chk("m1 drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
